invader_row_hits: RTL

- Consumer of the per-pixel sprite-index stream produced by the sprite-row drawer for one row of invaders.
- Compares that stream against the player-bullet pixel and reports which invader was struck.
- Owns the row's alive mask, which feeds back into the drawer's sprite-enable input.
- Mask updates are deferred to the frame boundary so a row is never altered mid-draw.

---
 rtl/invader_row_hits.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/invader_row_hits.sv
// Row hit detector: matches bullet pixels against the live sprite stream and owns the row alive mask (optional score: INVADER_SCORE_EN).
// Latency: hit_valid/hit_idx/bullet_kill one edge after the coincidence; mask, count and score commit on the first frame_start after hit_ack.
// Backpressure: a reported hit holds until hit_ack; further coincidences are ignored until the commit frame, so at most one kill per frame.
module invader_row_hits #(
    parameter int INVADERS_H = 11,
    parameter int IDX_W      = 4,
    parameter int POINTS     = 10,
    parameter int SCORE_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  row_reload,
    input  logic [IDX_W-1:0]      spr_draw,
    input  logic                  bullet_px,
    input  logic                  bullet_active,
    input  logic                  hit_ack,
    output logic [INVADERS_H-1:0] sprites,
    output logic                  hit_valid,
    output logic [IDX_W-1:0]      hit_idx,
    output logic                  bullet_kill,
    output logic [IDX_W-1:0]      alive_count,
    output logic                  row_empty,
    output logic [SCORE_W-1:0]    score
);

    localparam logic [1:0] ST_ARMED = 2'd0;
    localparam logic [1:0] ST_HIT   = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [INVADERS_H-1:0] sprites_q, sprites_d;
    logic [IDX_W-1:0]      alive_q, alive_d;
    logic [IDX_W-1:0]      hit_idx_q, hit_idx_d;
    logic                  hit_valid_q, hit_valid_d;
    logic                  bullet_kill_q, bullet_kill_d;

    logic                  spr_alive;
    logic [INVADERS_H-1:0] clr_mask;
    logic                  coinc;
    logic                  commit;

    // Out-of-range indices (0 or above the row width) never match any slot, so they read as dead.
    always_comb begin
        spr_alive = 1'b0;
        clr_mask  = '1;
        for (int k = 0; k < INVADERS_H; k++) begin
            if (spr_draw == IDX_W'(k + 1)) spr_alive = sprites_q[k];
            if (hit_idx_q == IDX_W'(k + 1)) clr_mask[k] = 1'b0;
        end
    end

    assign coinc  = spr_alive & bullet_px & bullet_active;
    assign commit = !row_reload && (state_q == ST_HELD) && frame_start;

    always_comb begin
        state_d       = state_q;
        sprites_d     = sprites_q;
        alive_d       = alive_q;
        hit_idx_d     = hit_idx_q;
        hit_valid_d   = hit_valid_q;
        bullet_kill_d = 1'b0;
        if (row_reload) begin
            state_d     = ST_ARMED;
            sprites_d   = '1;
            alive_d     = IDX_W'(INVADERS_H);
            hit_idx_d   = '0;
            hit_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (coinc) begin
                        hit_idx_d     = spr_draw;
                        hit_valid_d   = 1'b1;
                        bullet_kill_d = 1'b1;
                        state_d       = ST_HIT;
                    end
                end
                ST_HIT: begin
                    if (hit_ack) begin
                        hit_valid_d = 1'b0;
                        state_d     = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (commit) begin
                        sprites_d = sprites_q & clr_mask;
                        if (alive_q != '0) alive_d = alive_q - IDX_W'(1);
                        state_d   = ST_ARMED;
                    end
                end
                default: state_d = ST_ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_ARMED;
            sprites_q     <= '1;
            alive_q       <= IDX_W'(INVADERS_H);
            hit_idx_q     <= '0;
            hit_valid_q   <= 1'b0;
            bullet_kill_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sprites_q     <= sprites_d;
            alive_q       <= alive_d;
            hit_idx_q     <= hit_idx_d;
            hit_valid_q   <= hit_valid_d;
            bullet_kill_q <= bullet_kill_d;
        end
    end

`ifdef INVADER_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   score_sum;

    // One extra bit catches the carry so the counter pins at all-ones instead of wrapping.
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);

    always_comb begin
        score_d = score_q;
        if (commit) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) score_q <= '0;
        else      score_q <= score_d;
    end

    assign score = score_q;
`else
    // Scoring disabled: the port stays for a uniform interface and is tied to zero.
    assign score = SCORE_W'(POINTS) & SCORE_W'(0);
`endif

    assign sprites     = sprites_q;
    assign hit_valid   = hit_valid_q;
    assign hit_idx     = hit_idx_q;
    assign bullet_kill = bullet_kill_q;
    assign alive_count = alive_q;
    assign row_empty   = (sprites_q == '0);

endmodule
